oled_pixel_streamer: RTL and testbench

//  Frame-scan and SPI transmit end of the pixel_index/pixel_data interface that the sort visualisers drive.
//  - Walks the 96x64 raster and requests one RGB565 word per pixel from the renderer.
//  - Prefixes each frame with a column/row window command, then shifts the pixel words MSB-first to the SSD1331 PmodOLEDrgb over SPI mode 3.
//  - Panel power sequencing (resn/vccen/pmoden) is done by a separate sequencer and is out of scope here.

---
 rtl/oled_pixel_streamer_pkg.sv | 36 +++
 rtl/oled_pixel_streamer_if.sv | 27 ++
 rtl/oled_pixel_streamer_spi_shifter.sv | 65 ++++++
 rtl/oled_pixel_streamer.sv | 147 ++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pixel_streamer_pkg.sv
// rtl/oled_pixel_streamer_pkg.sv - shared constants, state encoding and command ROM for the OLED pixel streamer
package oled_pixel_streamer_pkg;

    localparam int PIX_IDX_W = 13;
    localparam int PIX_W     = 16;
    localparam int CMD_BYTES = 6;

    // SSD1331 window opcodes
    localparam logic [7:0] SSD_SET_COLUMN = 8'h15;
    localparam logic [7:0] SSD_SET_ROW    = 8'h75;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_PIX  = 2'd2,
        ST_GAP  = 2'd3
    } oled_state_t;

    // Window command sequence sent ahead of every frame: full-panel column then row range
    function automatic logic [7:0] cmd_rom(input logic [2:0] idx,
                                           input logic [7:0] last_col,
                                           input logic [7:0] last_row);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SSD_SET_COLUMN;
            3'd1:    b = 8'h00;
            3'd2:    b = last_col;
            3'd3:    b = SSD_SET_ROW;
            3'd4:    b = 8'h00;
            3'd5:    b = last_row;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_pixel_streamer_if.sv
// rtl/oled_pixel_streamer_if.sv - renderer pixel handshake plus SPI pins of the OLED streamer
interface oled_pixel_streamer_if;
    import oled_pixel_streamer_pkg::*;

    logic                 frame_begin;
    logic                 sending_pixels;
    logic                 sample_pixel;
    logic [PIX_IDX_W-1:0] pixel_index;
    logic [PIX_W-1:0]     pixel_data;
    logic                 cs;
    logic                 sdin;
    logic                 sclk;
    logic                 d_cn;

    modport master (
        output frame_begin, sending_pixels, sample_pixel, pixel_index,
        output cs, sdin, sclk, d_cn,
        input  pixel_data
    );

    modport slave (
        input  frame_begin, sending_pixels, sample_pixel, pixel_index,
        input  cs, sdin, sclk, d_cn,
        output pixel_data
    );

endinterface

// File: rtl/oled_pixel_streamer_spi_shifter.sv
// rtl/oled_pixel_streamer_spi_shifter.sv - SPI mode 3 MSB-first shifter for 8- or 16-bit words
module oled_spi_shifter #(
    parameter int SCLK_DIV = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] word,
    input  logic        len16,
    output logic        sclk,
    output logic        sdin,
    output logic        done
);

    localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(SCLK_DIV - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'((SCLK_DIV >= 2) ? SCLK_DIV - 2 : 0);

    logic [14:0]   shreg;
    logic [3:0]    bits_left;
    logic [PW-1:0] phase;
    logic          busy;

    // Bit engine: each bit is a low half then a high half; a new load is accepted in the
    // final high cycle so consecutive words run back-to-back. 8-bit words sit in word[15:8].
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk      <= 1'b1;
            sdin      <= 1'b0;
            shreg     <= '0;
            bits_left <= '0;
            phase     <= '0;
            busy      <= 1'b0;
        end else if (load) begin
            sclk      <= 1'b0;
            sdin      <= word[15];
            shreg     <= word[14:0];
            bits_left <= len16 ? 4'd15 : 4'd7;
            phase     <= '0;
            busy      <= 1'b1;
        end else if (busy) begin
            if (phase != PH_LAST) begin
                phase <= phase + 1'b1;
            end else begin
                phase <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else if (bits_left == 4'd0) begin
                    busy <= 1'b0;
                end else begin
                    sclk      <= 1'b0;
                    sdin      <= shreg[14];
                    shreg     <= {shreg[13:0], 1'b0};
                    bits_left <= bits_left - 4'd1;
                end
            end
        end
    end

    // done marks the cycle before the word's final cycle, leaving the caller one cycle
    // to register its load so the next word starts with no idle bit
    assign done = busy && (bits_left == 4'd0) &&
                  (sclk ? ((SCLK_DIV >= 2) && (phase == PH_PRE)) : (SCLK_DIV == 1));

endmodule

// File: rtl/oled_pixel_streamer.sv
// rtl/oled_pixel_streamer.sv - frame scan FSM, command ROM mux and pixel counter feeding the SPI shifter
module oled_pixel_streamer
    import oled_pixel_streamer_pkg::*;
#(
    parameter int WIDTH     = 96,
    parameter int HEIGHT    = 64,
    parameter int SCLK_DIV  = 1,
    parameter int FRAME_GAP = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    oled_pixel_streamer_if.master bus
);

    localparam int N_PIX = WIDTH * HEIGHT;
    localparam logic [PIX_IDX_W-1:0] LAST_PIX = PIX_IDX_W'(N_PIX - 1);
    localparam logic [2:0] LAST_CMD = 3'(CMD_BYTES - 1);
    localparam logic [7:0] LAST_COL = 8'(WIDTH - 1);
    localparam logic [7:0] LAST_ROW = 8'(HEIGHT - 1);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

    oled_state_t          state;
    logic [2:0]           cmd_idx;
    logic [GW-1:0]        gap_cnt;
    logic [PIX_IDX_W-1:0] pix_idx;
    logic                 load_q;
    logic                 len16_q;
    logic                 last_loaded;
    logic                 tail;
    logic                 frame_begin_q;
    logic                 sample_q;
    logic                 sending_q;
    logic                 cs_q;
    logic                 d_cn_q;

    logic [15:0]          shift_word;
    logic                 shift_done;
    logic                 start_frame;

    // Pixel words come straight from the renderer on the load cycle; command bytes from the ROM
    assign shift_word = len16_q ? bus.pixel_data
                                : {cmd_rom(cmd_idx, LAST_COL, LAST_ROW), 8'h00};

    // enable only matters while idle or on the last gap cycle; a running frame always completes
    assign start_frame = enable &&
                         ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST)));

    oled_spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
        .clk    (clk),
        .resetn (resetn),
        .load   (load_q),
        .word   (shift_word),
        .len16  (len16_q),
        .sclk   (bus.sclk),
        .sdin   (bus.sdin),
        .done   (shift_done)
    );

    // Frame FSM: IDLE -> CMD -> PIX -> GAP -> (CMD | IDLE), all outputs registered
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cmd_idx       <= '0;
            gap_cnt       <= '0;
            pix_idx       <= '0;
            load_q        <= 1'b0;
            len16_q       <= 1'b0;
            last_loaded   <= 1'b0;
            tail          <= 1'b0;
            frame_begin_q <= 1'b0;
            sample_q      <= 1'b0;
            sending_q     <= 1'b0;
            cs_q          <= 1'b1;
            d_cn_q        <= 1'b0;
        end else begin
            frame_begin_q <= 1'b0;
            sample_q      <= 1'b0;
            load_q        <= 1'b0;
            if (start_frame) begin
                state         <= ST_CMD;
                frame_begin_q <= 1'b1;
                load_q        <= 1'b1;
                cs_q          <= 1'b0;
                d_cn_q        <= 1'b0;
                len16_q       <= 1'b0;
                cmd_idx       <= '0;
                pix_idx       <= '0;
                last_loaded   <= 1'b0;
                tail          <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_CMD: begin
                        if (shift_done) begin
                            load_q <= 1'b1;
                            if (cmd_idx == LAST_CMD) begin
                                state     <= ST_PIX;
                                len16_q   <= 1'b1;
                                sample_q  <= 1'b1;
                                sending_q <= 1'b1;
                                d_cn_q    <= 1'b1;
                            end else begin
                                cmd_idx <= cmd_idx + 3'd1;
                            end
                        end
                    end
                    ST_PIX: begin
                        // index advances after each load and parks on the last pixel
                        if (sample_q) begin
                            if (pix_idx == LAST_PIX) last_loaded <= 1'b1;
                            else                     pix_idx     <= pix_idx + 1'b1;
                        end
                        if (tail) begin
                            tail      <= 1'b0;
                            cs_q      <= 1'b1;
                            sending_q <= 1'b0;
                            gap_cnt   <= '0;
                            state     <= ST_GAP;
                        end else if (shift_done) begin
                            if (last_loaded) begin
                                tail <= 1'b1;
                            end else begin
                                load_q   <= 1'b1;
                                sample_q <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) state   <= ST_IDLE;
                        else                     gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.frame_begin    = frame_begin_q;
    assign bus.sample_pixel   = sample_q;
    assign bus.sending_pixels = sending_q;
    assign bus.pixel_index    = pix_idx;
    assign bus.cs             = cs_q;
    assign bus.d_cn           = d_cn_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// tb/tb_oled_pixel_streamer.sv - self-checking bench for oled_pixel_streamer
module tb_oled_pixel_streamer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 1;
    localparam int G = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;

    oled_pixel_streamer_if bus();

    assign bus.pixel_data = 16'(bus.pixel_index) * 16'h0101;

    oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .SCLK_DIV(D), .FRAME_GAP(G)) dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [16:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_frame();
        logic [7:0] cmds [6];
        cmds = '{8'h15, 8'h00, 8'h03, 8'h75, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, cmds[i]});
        for (int i = 0; i < W * H; i++) exp_q.push_back({1'b1, 8'(i), 8'(i)});
    endtask

    // SPI and handshake monitor
    int   nbits = 0;
    logic [15:0] sh = '0;
    logic word_dcn = 1'b0;
    logic prev_sclk = 1'b1;
    int   fb_count = 0;
    int   samp_in_frame = 0;
    int   last_samp_cyc = 0;
    int   words_in_frame = 0;
    int   cs_run = 0;
    int   last_cs_run = 0;
    logic [12:0] prev_pix = '0;
    logic [12:0] pix_before_fb = '0;
    bit   first_frame = 1'b1;

    always @(negedge clk) begin
        logic [16:0] rx;
        logic [16:0] e;
        if (mon_en) begin
            if (!resetn) first_frame = 1'b1;
            if (bus.frame_begin) begin
                fb_count++;
                if (!first_frame) chk("samples_per_frame", 32'(samp_in_frame), 32'(W * H));
                first_frame = 1'b0;
                samp_in_frame = 0;
                words_in_frame = 0;
                last_cs_run = cs_run;
                pix_before_fb = prev_pix;
            end
            if (bus.sample_pixel) begin
                chk("sample_index", 32'(bus.pixel_index), 32'(samp_in_frame));
                chk("sending_at_sample", 32'(bus.sending_pixels), 32'd1);
                if (samp_in_frame > 0) chk("sample_spacing", 32'(cyc - last_samp_cyc), 32'(32 * D));
                last_samp_cyc = cyc;
                samp_in_frame++;
            end
            if (bus.cs) begin
                nbits = 0;
                chk("sclk_idle_high", 32'(bus.sclk), 32'd1);
            end else if (bus.sclk && !prev_sclk) begin
                if (nbits == 0) word_dcn = bus.d_cn;
                sh = {sh[14:0], bus.sdin};
                nbits++;
                if (nbits == (word_dcn ? 16 : 8)) begin
                    rx = {word_dcn, word_dcn ? sh : {8'h00, sh[7:0]}};
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    chk("spi_word", 32'(rx), 32'(e));
                    words_in_frame++;
                    nbits = 0;
                end
            end
            if (!bus.cs) begin
                chk("sending_pixels_phase", 32'(bus.sending_pixels), 32'(words_in_frame >= 6));
                chk("d_cn_phase", 32'(bus.d_cn), 32'(words_in_frame >= 6));
            end
            if (bus.cs) cs_run++;
            else        cs_run = 0;
            prev_pix = bus.pixel_index;
        end
        prev_sclk = bus.sclk;
    end

    task automatic wait_fb(input int n);
        int k = 0;
        while (fb_count < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_begin_count", 32'(fb_count), 32'(n));
    endtask

    task automatic wait_sample(input int v);
        int k = 0;
        while (!(bus.sample_pixel === 1'b1 && bus.pixel_index == 13'(v)) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wait_sample", 32'(bus.sample_pixel), 32'd1);
    endtask

    task automatic wait_exp_empty(input int max);
        int k = 0;
        while (exp_q.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("words_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cs"}, 32'(bus.cs), 32'd1);
        chk({tag, "_sclk"}, 32'(bus.sclk), 32'd1);
        chk({tag, "_sdin"}, 32'(bus.sdin), 32'd0);
        chk({tag, "_d_cn"}, 32'(bus.d_cn), 32'd0);
        chk({tag, "_pixel_index"}, 32'(bus.pixel_index), 32'd0);
        chk({tag, "_frame_begin"}, 32'(bus.frame_begin), 32'd0);
        chk({tag, "_sample_pixel"}, 32'(bus.sample_pixel), 32'd0);
        chk({tag, "_sending"}, 32'(bus.sending_pixels), 32'd0);
    endtask

    initial begin
        int fb_snap;
        // reset held with enable high
        resetn = 1'b0;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        mon_en = 1'b1;

        // four identical frames expected back-to-back
        for (int f = 0; f < 4; f++) push_frame();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("fb_not_yet", 32'(bus.frame_begin), 32'd0);
        @(negedge clk);
        chk("fb_latency", 32'(bus.frame_begin), 32'd1);
        chk("cs_low_at_fb", 32'(bus.cs), 32'd0);
        @(negedge clk);
        chk("first_sclk_low", 32'(bus.sclk), 32'd0);
        chk("fb_single_pulse", 32'(bus.frame_begin), 32'd0);

        // continuous frames: exact gap and index wrap
        for (int f = 2; f <= 4; f++) begin
            wait_fb(f);
            chk("gap_cs_high_cycles", 32'(last_cs_run), 32'(G));
            chk("index_before_wrap", 32'(pix_before_fb), 32'(W * H - 1));
            chk("index_after_wrap", 32'(bus.pixel_index), 32'd0);
        end

        // drop enable during pixel 3 of frame 4
        wait_sample(3);
        enable = 1'b0;
        wait_exp_empty(600);
        fb_snap = fb_count;
        repeat (500) @(negedge clk);
        chk("no_frame_after_disable", 32'(fb_count), 32'(fb_snap));
        chk("cs_high_idle", 32'(bus.cs), 32'd1);
        chk("frame4_samples", 32'(samp_in_frame), 32'(W * H));

        // restart, then reset for one cycle during pixel 2
        push_frame();
        enable = 1'b1;
        wait_fb(5);
        wait_sample(2);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk_reset_values("midframe_reset");
        exp_q.delete();
        push_frame();
        wait_fb(6);
        wait_exp_empty(600);
        chk("restart_samples", 32'(samp_in_frame), 32'(W * H));
        enable = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
